// File: rtl/l2_output_encoder.sv
// rtl/l2_output_encoder.sv - three-channel outbound FIFO encoder with fence drain tracking
module l2_output_encoder #(
    parameter int DEPTH   = 2,
    parameter int REQ_W   = 128,
    parameter int RSP_W   = 160,
    parameter int RDRSP_W = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               send_req_out,
    input  logic [REQ_W-1:0]   send_req_out_data,
    input  logic               send_rsp_out,
    input  logic [RSP_W-1:0]   send_rsp_out_data,
    input  logic               send_rd_rsp,
    input  logic [RDRSP_W-1:0] send_rd_rsp_data,
    output logic               req_out_full,
    output logic               rsp_out_full,
    output logic               rd_rsp_full,
    output logic               l2_req_out_valid_int,
    input  logic               l2_req_out_ready_int,
    output logic [REQ_W-1:0]   l2_req_out_data,
    output logic               l2_rsp_out_valid_int,
    input  logic               l2_rsp_out_ready_int,
    output logic [RSP_W-1:0]   l2_rsp_out_data,
    output logic               l2_rd_rsp_valid_int,
    input  logic               l2_rd_rsp_ready_int,
    output logic [RDRSP_W-1:0] l2_rd_rsp_data,
    input  logic               drain_req,
    output logic               drain_in_progress,
    output logic               drain_done,
    output logic               overflow_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_DONE} drain_state_t;
    drain_state_t state, state_nxt;

    logic [REQ_W-1:0]   req_mem [DEPTH];
    logic [RSP_W-1:0]   rsp_mem [DEPTH];
    logic [RDRSP_W-1:0] rd_mem  [DEPTH];

    logic [AW-1:0] req_rd, req_wr, rsp_rd, rsp_wr, rd_rd, rd_wr;
    logic [CW-1:0] req_cnt, rsp_cnt, rd_cnt;
    logic [CW-1:0] req_cnt_nxt, rsp_cnt_nxt, rd_cnt_nxt;
    logic          req_push, req_pop, rsp_push, rsp_pop, rd_push, rd_pop;
    logic          ovf_now;

    // A full FIFO still accepts a push when its head retires on the same edge
    assign req_pop     = l2_req_out_valid_int && l2_req_out_ready_int;
    assign req_push    = send_req_out && ((req_cnt != FULL_CNT) || req_pop);
    assign req_cnt_nxt = req_cnt + CW'(req_push) - CW'(req_pop);

    assign rsp_pop     = l2_rsp_out_valid_int && l2_rsp_out_ready_int;
    assign rsp_push    = send_rsp_out && ((rsp_cnt != FULL_CNT) || rsp_pop);
    assign rsp_cnt_nxt = rsp_cnt + CW'(rsp_push) - CW'(rsp_pop);

    assign rd_pop      = l2_rd_rsp_valid_int && l2_rd_rsp_ready_int;
    assign rd_push     = send_rd_rsp && ((rd_cnt != FULL_CNT) || rd_pop);
    assign rd_cnt_nxt  = rd_cnt + CW'(rd_push) - CW'(rd_pop);

    // Any send that was refused because its FIFO stayed full
    assign ovf_now = (send_req_out && !req_push) || (send_rsp_out && !rsp_push)
                  || (send_rd_rsp && !rd_push);

    assign req_out_full = (req_cnt == FULL_CNT);
    assign rsp_out_full = (rsp_cnt == FULL_CNT);
    assign rd_rsp_full  = (rd_cnt == FULL_CNT);

    assign l2_req_out_valid_int = (req_cnt != '0);
    assign l2_rsp_out_valid_int = (rsp_cnt != '0);
    assign l2_rd_rsp_valid_int  = (rd_cnt != '0);

    assign l2_req_out_data = req_mem[req_rd];
    assign l2_rsp_out_data = rsp_mem[rsp_rd];
    assign l2_rd_rsp_data  = rd_mem[rd_rd];

    // Entry storage is not reset; payloads are only observed while valid
    always_ff @(posedge clk) begin
        if (req_push) req_mem[req_wr] <= send_req_out_data;
        if (rsp_push) rsp_mem[rsp_wr] <= send_rsp_out_data;
        if (rd_push)  rd_mem[rd_wr]   <= send_rd_rsp_data;
    end

    // Pointers, counts, sticky overflow and drain state
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_rd       <= '0;
            req_wr       <= '0;
            req_cnt      <= '0;
            rsp_rd       <= '0;
            rsp_wr       <= '0;
            rsp_cnt      <= '0;
            rd_rd        <= '0;
            rd_wr        <= '0;
            rd_cnt       <= '0;
            overflow_err <= 1'b0;
            state        <= ST_IDLE;
        end else begin
            if (req_pop)  req_rd <= req_rd + AW'(1);
            if (req_push) req_wr <= req_wr + AW'(1);
            if (rsp_pop)  rsp_rd <= rsp_rd + AW'(1);
            if (rsp_push) rsp_wr <= rsp_wr + AW'(1);
            if (rd_pop)   rd_rd  <= rd_rd + AW'(1);
            if (rd_push)  rd_wr  <= rd_wr + AW'(1);
            req_cnt <= req_cnt_nxt;
            rsp_cnt <= rsp_cnt_nxt;
            rd_cnt  <= rd_cnt_nxt;
            if (ovf_now) overflow_err <= 1'b1;
            state <= state_nxt;
        end
    end

    // Drain FSM: leave DRAIN once every channel is empty after this edge
    always_comb begin
        state_nxt         = state;
        drain_in_progress = 1'b0;
        drain_done        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (drain_req) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                drain_in_progress = 1'b1;
                if (req_cnt_nxt == '0 && rsp_cnt_nxt == '0 && rd_cnt_nxt == '0)
                    state_nxt = ST_DONE;
            end
            ST_DONE: begin
                drain_done = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_l2_output_encoder.sv
// tb/tb_l2_output_encoder.sv - directed table and sequence bench for l2_output_encoder
module tb_l2_output_encoder;
    logic         clk = 1'b0;
    logic         rst;
    logic         send_req_out, send_rsp_out, send_rd_rsp;
    logic [127:0] send_req_out_data;
    logic [159:0] send_rsp_out_data;
    logic [127:0] send_rd_rsp_data;
    logic         req_out_full, rsp_out_full, rd_rsp_full;
    logic         l2_req_out_valid_int, l2_req_out_ready_int;
    logic [127:0] l2_req_out_data;
    logic         l2_rsp_out_valid_int, l2_rsp_out_ready_int;
    logic [159:0] l2_rsp_out_data;
    logic         l2_rd_rsp_valid_int, l2_rd_rsp_ready_int;
    logic [127:0] l2_rd_rsp_data;
    logic         drain_req, drain_in_progress, drain_done, overflow_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    l2_output_encoder dut (
        .clk(clk), .rst(rst),
        .send_req_out(send_req_out), .send_req_out_data(send_req_out_data),
        .send_rsp_out(send_rsp_out), .send_rsp_out_data(send_rsp_out_data),
        .send_rd_rsp(send_rd_rsp), .send_rd_rsp_data(send_rd_rsp_data),
        .req_out_full(req_out_full), .rsp_out_full(rsp_out_full), .rd_rsp_full(rd_rsp_full),
        .l2_req_out_valid_int(l2_req_out_valid_int), .l2_req_out_ready_int(l2_req_out_ready_int),
        .l2_req_out_data(l2_req_out_data),
        .l2_rsp_out_valid_int(l2_rsp_out_valid_int), .l2_rsp_out_ready_int(l2_rsp_out_ready_int),
        .l2_rsp_out_data(l2_rsp_out_data),
        .l2_rd_rsp_valid_int(l2_rd_rsp_valid_int), .l2_rd_rsp_ready_int(l2_rd_rsp_ready_int),
        .l2_rd_rsp_data(l2_rd_rsp_data),
        .drain_req(drain_req), .drain_in_progress(drain_in_progress),
        .drain_done(drain_done), .overflow_err(overflow_err)
    );

    typedef struct {
        logic       sreq; logic [7:0] dreq; logic rreq;
        logic       srsp; logic [7:0] drsp; logic rrsp;
        logic       srd;  logic [7:0] drd;  logic rrd;
        logic       vreq; logic [7:0] xreq; logic freq;
        logic       vrsp; logic [7:0] xrsp; logic frsp;
        logic       vrd;  logic [7:0] xrd;  logic frd;
        logic       ovf;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        send_req_out = 0; send_rsp_out = 0; send_rd_rsp = 0;
        send_req_out_data = '0; send_rsp_out_data = '0; send_rd_rsp_data = '0;
        l2_req_out_ready_int = 0; l2_rsp_out_ready_int = 0; l2_rd_rsp_ready_int = 0;
        drain_req = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 0;
        step();
        rst = 1;
    endtask

    int tx, rx, cyc;

    initial begin
        rst = 1;
        idle_inputs();
        #1;
        do_reset();
        chk("rst_req_valid", l2_req_out_valid_int, 0);
        chk("rst_full", {req_out_full, rsp_out_full, rd_rsp_full}, 0);
        chk("rst_drain", {drain_in_progress, drain_done}, 0);
        chk("rst_ovf", overflow_err, 0);

        // single pass-through, rd_rsp full+pop, rsp overflow
        tbl[0]  = '{1,8'hA5,1, 0,0,0, 0,0,0,  1,8'hA5,0, 0,0,0, 0,0,0, 0};
        tbl[1]  = '{0,0,1,     0,0,0, 0,0,0,  0,0,0,     0,0,0, 0,0,0, 0};
        tbl[2]  = '{0,0,0, 0,0,0, 1,8'h1,0,   0,0,0, 0,0,0, 1,8'h1,0, 0};
        tbl[3]  = '{0,0,0, 0,0,0, 1,8'h2,0,   0,0,0, 0,0,0, 1,8'h1,1, 0};
        tbl[4]  = '{0,0,0, 0,0,0, 1,8'h3,1,   0,0,0, 0,0,0, 1,8'h2,1, 0};
        tbl[5]  = '{0,0,0, 0,0,0, 0,0,1,      0,0,0, 0,0,0, 1,8'h3,0, 0};
        tbl[6]  = '{0,0,0, 0,0,0, 0,0,1,      0,0,0, 0,0,0, 0,0,0,    0};
        tbl[7]  = '{0,0,0, 1,8'h1,0, 0,0,0,   0,0,0, 1,8'h1,0, 0,0,0, 0};
        tbl[8]  = '{0,0,0, 1,8'h2,0, 0,0,0,   0,0,0, 1,8'h1,1, 0,0,0, 0};
        tbl[9]  = '{0,0,0, 1,8'h3,0, 0,0,0,   0,0,0, 1,8'h1,1, 0,0,0, 1};
        tbl[10] = '{0,0,0, 0,0,1, 0,0,0,      0,0,0, 1,8'h2,0, 0,0,0, 1};
        tbl[11] = '{0,0,0, 0,0,1, 0,0,0,      0,0,0, 0,0,0,    0,0,0, 1};

        for (int i = 0; i < 12; i++) begin
            send_req_out = tbl[i].sreq; send_req_out_data = 128'(tbl[i].dreq);
            l2_req_out_ready_int = tbl[i].rreq;
            send_rsp_out = tbl[i].srsp; send_rsp_out_data = 160'(tbl[i].drsp);
            l2_rsp_out_ready_int = tbl[i].rrsp;
            send_rd_rsp = tbl[i].srd; send_rd_rsp_data = 128'(tbl[i].drd);
            l2_rd_rsp_ready_int = tbl[i].rrd;
            step();
            chk($sformatf("v%0d_req_valid", i), l2_req_out_valid_int, tbl[i].vreq);
            chk($sformatf("v%0d_rsp_valid", i), l2_rsp_out_valid_int, tbl[i].vrsp);
            chk($sformatf("v%0d_rd_valid", i), l2_rd_rsp_valid_int, tbl[i].vrd);
            if (tbl[i].vreq) chk($sformatf("v%0d_req_data", i), l2_req_out_data, 160'(tbl[i].xreq));
            if (tbl[i].vrsp) chk($sformatf("v%0d_rsp_data", i), l2_rsp_out_data, 160'(tbl[i].xrsp));
            if (tbl[i].vrd)  chk($sformatf("v%0d_rd_data", i), l2_rd_rsp_data, 160'(tbl[i].xrd));
            chk($sformatf("v%0d_full", i), {req_out_full, rsp_out_full, rd_rsp_full},
                {tbl[i].freq, tbl[i].frsp, tbl[i].frd});
            chk($sformatf("v%0d_ovf", i), overflow_err, tbl[i].ovf);
            chk($sformatf("v%0d_drain", i), drain_in_progress, 0);
        end

        // five values through req with random ready; exercises pointer wrap
        do_reset();
        tx = 0; rx = 0; cyc = 0;
        while (rx < 5 && cyc < 200) begin
            l2_req_out_ready_int = 1'($urandom_range(0, 1));
            send_req_out = (tx < 5) && !req_out_full;
            send_req_out_data = 128'(8'h10 + tx);
            if (l2_req_out_valid_int && l2_req_out_ready_int) begin
                chk($sformatf("seq_data%0d", rx), l2_req_out_data, 160'(8'h10 + rx));
                rx++;
            end
            if (send_req_out) tx++;
            step();
            cyc++;
        end
        chk("seq_rx_count", rx, 5);
        idle_inputs();
        chk("seq_empty", l2_req_out_valid_int, 0);
        chk("seq_ovf", overflow_err, 0);

        // drain with two pending req entries
        send_req_out = 1; send_req_out_data = 128'h20; step();
        send_req_out_data = 128'h21; step();
        send_req_out = 0; drain_req = 1; step();
        drain_req = 0;
        chk("drn_in_prog0", {drain_in_progress, drain_done}, 2'b10);
        drain_req = 1; step();
        drain_req = 0;
        chk("drn_in_prog1", {drain_in_progress, drain_done}, 2'b10);
        l2_req_out_ready_int = 1; step();
        chk("drn_after_pop1", {drain_in_progress, drain_done}, 2'b10);
        chk("drn_head", l2_req_out_data, 160'h21);
        step();
        chk("drn_done", {drain_in_progress, drain_done}, 2'b01);
        step();
        chk("drn_idle", {drain_in_progress, drain_done}, 2'b00);
        l2_req_out_ready_int = 0;

        // drain with everything already empty
        drain_req = 1; step();
        drain_req = 0;
        chk("edrn_1", {drain_in_progress, drain_done}, 2'b10);
        step();
        chk("edrn_2", {drain_in_progress, drain_done}, 2'b01);
        step();
        chk("edrn_3", {drain_in_progress, drain_done}, 2'b00);

        // reset with data in every channel, overflow set and drain active
        send_req_out = 1; send_rsp_out = 1; send_rd_rsp = 1;
        send_req_out_data = 128'h7; send_rsp_out_data = 160'h8; send_rd_rsp_data = 128'h9;
        step(); step(); step();
        send_req_out = 0; send_rsp_out = 0; send_rd_rsp = 0;
        drain_req = 1; step();
        drain_req = 0;
        chk("pre_rst_state", {overflow_err, drain_in_progress, req_out_full, rsp_out_full, rd_rsp_full}, 5'b11111);
        rst = 0; step(); rst = 1;
        chk("post_rst_valids", {l2_req_out_valid_int, l2_rsp_out_valid_int, l2_rd_rsp_valid_int}, 0);
        chk("post_rst_full", {req_out_full, rsp_out_full, rd_rsp_full}, 0);
        chk("post_rst_misc", {drain_in_progress, drain_done, overflow_err}, 0);
        send_req_out = 1; send_req_out_data = 128'hA5; l2_req_out_ready_int = 1; step();
        send_req_out = 0;
        chk("post_rst_push_valid", l2_req_out_valid_int, 1);
        chk("post_rst_push_data", l2_req_out_data, 160'hA5);
        step();
        chk("post_rst_pop", l2_req_out_valid_int, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/l2_output_encoder.md
Name: l2_output_encoder

Overview:
Outbound counterpart of the L2 input decoder. It accepts send commands from the L2 controller FSM and buffers each in a per-channel FIFO. It drives valid/data toward three interfaces and retires entries on the interface ready handshake:
- req_out: L2 to LLC requests
- rsp_out: L2 to LLC/L2 responses and writebacks
- rd_rsp: L2 to CPU read responses

It also tracks outbound drain for fences and reports drain_in_progress back to the input decoder.

Parameters:
- DEPTH, 2, entries per channel FIFO; power of 2, >= 2.
- REQ_W, 128, flattened req_out payload width (coh_msg, hprot, addr, line, word_mask).
- RSP_W, 160, flattened rsp_out payload width (coh_msg, req_id, to_req, addr, line, word_mask).
- RDRSP_W, 128, flattened rd_rsp payload width (line).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- send_req_out  in  1  FSM push request, req channel
- send_req_out_data  in  REQ_W  req payload
- send_rsp_out  in  1  FSM push request, rsp channel
- send_rsp_out_data  in  RSP_W  rsp payload
- send_rd_rsp  in  1  FSM push request, rd_rsp channel
- send_rd_rsp_data  in  RDRSP_W  rd_rsp payload
- req_out_full  out  1  req FIFO count == DEPTH
- rsp_out_full  out  1  rsp FIFO count == DEPTH
- rd_rsp_full  out  1  rd_rsp FIFO count == DEPTH
- l2_req_out_valid_int  out  1  req head valid
- l2_req_out_ready_int  in  1  req interface ready
- l2_req_out_data  out  REQ_W  req head payload
- l2_rsp_out_valid_int  out  1  rsp head valid
- l2_rsp_out_ready_int  in  1  rsp interface ready
- l2_rsp_out_data  out  RSP_W  rsp head payload
- l2_rd_rsp_valid_int  out  1  rd_rsp head valid
- l2_rd_rsp_ready_int  in  1  rd_rsp interface ready
- l2_rd_rsp_data  out  RDRSP_W  rd_rsp head payload
- drain_req  in  1  one-cycle pulse: fence requests outbound drain
- drain_in_progress  out  1  drain FSM in DRAIN
- drain_done  out  1  one-cycle pulse when drain completes
- overflow_err  out  1  sticky: push attempted while full and no pop that cycle

Behaviour:
- Reset (rst==0 at posedge clk): every FIFO count, read pointer and write pointer goes to 0. All valids = 0, full = 0, drain FSM = IDLE, drain_done = 0, overflow_err = 0. Data outputs are don't-care while valid = 0. Reset mid-operation discards all buffered entries with no handshake.
- Each channel uses an independent circular FIFO:
  - count width = clog2(DEPTH)+1.
  - Pointers wrap from DEPTH-1 to 0.
  - valid = (count != 0); data = entry[rd_ptr]; both are driven straight from registers.
- pop = valid && ready; pop advances rd_ptr.
- push = send && (count < DEPTH || pop); push writes entry[wr_ptr] and advances wr_ptr.
- count update: count_next = count + push - pop.
- Latency: a push at edge N gives valid=1 with that payload after edge N (zero bubble). An entry already at the head can pop on the same edge a new entry is pushed.
- Full and pop in the same cycle: the push is accepted, count stays DEPTH, FIFO order is preserved.
- send while full and no pop: the entry is dropped and overflow_err sets and holds until reset. The FSM must gate its pushes on *_full.
- Channels never block each other, and there is no cross-channel ordering.
- Drain FSM:
  - IDLE: drain_req goes to DRAIN.
  - DRAIN: drain_in_progress=1. When all three counts are 0 after this edge's update, go to DONE.
  - DONE: drain_done=1 for exactly one cycle, then IDLE.
  - drain_req outside IDLE is ignored.
  - drain_req with all FIFOs already empty: DRAIN for 1 cycle, then DONE.
  - Pushes during DRAIN are still accepted and extend DRAIN.
- Data is unchanged while valid=1 and ready=0, since the head only changes on pop.

Test Plan:
1. send_req_out=1 with data=0xA5, ready=1 throughout → valid=1 for exactly 1 cycle after the push edge with data 0xA5, popped next edge, count back to 0.
2. rsp ready=0, push 0x1 then 0x2 (DEPTH=2) → rsp_out_full=1. A third push of 0x3 is dropped and overflow_err=1. Raising ready yields 0x1 then 0x2, then valid=0.
3. rd_rsp full with ready=1 and a push of 0x3 in the same cycle → accepted, count stays 2, output order 0x1, 0x2, 0x3, overflow_err stays 0.
4. Push 5 sequential values 0x10..0x14 through req with random ready → received in order with no loss or duplication, checking pointer wrap.
5. Two req entries pending with ready=0, then drain_req → drain_in_progress=1 until the second pop. drain_done pulses exactly 1 cycle after the state reaches DONE, then IDLE. A drain_req with empty FIFOs gives drain_done 2 cycles after the pulse.
6. Reset asserted with entries in all channels and DRAIN active → after the edge all valids=0, full=0, drain_in_progress=0, overflow_err=0. A subsequent push behaves as in scenario 1.
